// File: rtl/ones_count_arbiter.sv
// Round-robin shared serial ones counter: grants one requester a fixed window,
// counts the 1s on its data line, then returns {id, count} over valid/ready.
module ones_count_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 5,
  parameter int ID_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [ID_W-1:0]  res_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN_LEN - 1);
  localparam logic [ID_W:0]    NREQ_EXT  = (ID_W + 1)'(N_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] win_q, win_d;

  // First set request scanning upward from ptr, wrapping at N_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] sel;
    logic            found;
    logic [ID_W:0]   cand;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(k);
      if (cand >= NREQ_EXT) begin
        cand = cand - NREQ_EXT;
      end
      if (!found && r[cand[ID_W-1:0]]) begin
        sel   = cand[ID_W-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          id_d    = rr_pick(req, rr_ptr_q);
          cnt_d   = '0;
          win_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // The last sample is taken on the same edge that leaves COUNT.
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, data[id_q]};
        win_d = win_q + 1'b1;
        if (win_q == WIN_LAST) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          rr_ptr_d = next_id(id_q);
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from state so reset clears them without a clock.
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == REPORT);
  assign gnt       = (state_q == COUNT) ? (N_REQ'(1) << id_q) : '0;
  assign res_count = res_valid ? cnt_q : '0;
  assign res_id    = res_valid ? id_q : '0;

endmodule
